// File: rtl/ser_pkg.sv
// Shared definitions for the word serializer: state encoding, default sizing
// and the bit-index width helper.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIV   = 1;
  localparam int DEF_CNT_W = 8;

  function automatic int idx_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Word-in / bit-out bundle between a word source (master) and the serializer (slave).
interface word_serializer_if
  import ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic [CNT_W-1:0] words_sent;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, ser_valid, busy, words_sent
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, ser_valid, busy, words_sent
  );

endinterface

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts 0..DIV-1 while enabled, tick is high in the last
// cycle of each period; clr restarts the period (word load).
module bit_tick_gen
  import ser_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial front end: first bit one cycle after the accepting edge, one bit per DIV cycles.
// Backpressure: in_ready drops only while the one-word holding register is full.
// SER_MSB_FIRST_EN selects MSB-first bit order (default LSB-first).
module word_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  word_serializer_if.slave bus
);

  localparam int            IW       = idx_w(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [IW-1:0]    bit_idx;
  logic [CNT_W-1:0] words_sent;
  logic             ser_out;
  logic             ser_valid;

  logic             xfer;
  logic             tick;
  logic             eow;
  logic             load;
  logic [WIDTH-1:0] load_data;

`ifdef SER_MSB_FIRST_EN
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return w[WIDTH-1];
  endfunction
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return w << 1;
  endfunction
`else
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return w[0];
  endfunction
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return w >> 1;
  endfunction
`endif

  assign xfer = bus.in_valid && !hold_full;
  assign eow  = (state == SHIFT) && tick && (bit_idx == LAST_IDX);

  // The shifter is (re)loaded from idle, by the held word at end-of-word, or by
  // a word arriving exactly at end-of-word when nothing is held.
  assign load      = ((state == IDLE) && xfer) || (eow && (hold_full || xfer));
  assign load_data = hold_full ? hold : bus.in_data;

  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .en   (state == SHIFT),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      bit_idx    <= '0;
      words_sent <= '0;
      ser_out    <= 1'b0;
      ser_valid  <= 1'b0;
    end else begin
      ser_valid <= 1'b0;

      if (eow) begin
        words_sent <= words_sent + 1'b1;
      end

      if (load) begin
        shreg     <= advance(load_data);
        ser_out   <= first_bit(load_data);
        ser_valid <= 1'b1;
        bit_idx   <= '0;
        hold_full <= 1'b0;
        state     <= SHIFT;
      end else if (eow) begin
        state <= IDLE;
      end else if ((state == SHIFT) && tick) begin
        shreg     <= advance(shreg);
        ser_out   <= first_bit(shreg);
        ser_valid <= 1'b1;
        bit_idx   <= bit_idx + 1'b1;
      end

      // Mid-word arrivals park in the holding register; end-of-word arrivals load directly.
      if ((state == SHIFT) && xfer && !eow) begin
        hold      <= bus.in_data;
        hold_full <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = !hold_full;
  assign bus.busy       = (state == SHIFT) || hold_full;
  assign bus.ser_out    = ser_out;
  assign bus.ser_valid  = ser_valid;
  assign bus.words_sent = words_sent;

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: DUT0 with DIV=1, DUT1 with DIV=3, each checked every
// cycle against a positional stream model, plus literal expectations for directed cases.
module tb_word_serializer;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        vld [2];
  logic [15:0] dat [2];
  logic        rdy [2];
  logic        so  [2];
  logic        sv  [2];
  logic        bsy [2];
  logic [7:0]  ws  [2];

  word_serializer_if #(.WIDTH(16), .CNT_W(8)) b0 ();
  word_serializer_if #(.WIDTH(16), .CNT_W(8)) b1 ();

  assign b0.in_valid = vld[0];
  assign b0.in_data  = dat[0];
  assign b1.in_valid = vld[1];
  assign b1.in_data  = dat[1];
  assign rdy[0] = b0.in_ready;
  assign so[0]  = b0.ser_out;
  assign sv[0]  = b0.ser_valid;
  assign bsy[0] = b0.busy;
  assign ws[0]  = b0.words_sent;
  assign rdy[1] = b1.in_ready;
  assign so[1]  = b1.ser_out;
  assign sv[1]  = b1.ser_valid;
  assign bsy[1] = b1.busy;
  assign ws[1]  = b1.words_sent;

  word_serializer #(.WIDTH(16), .DIV(1), .CNT_W(8)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  word_serializer #(.WIDTH(16), .DIV(3), .CNT_W(8)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, i, $time, act, exp);
    end
  endtask

  // Stream model: word loaded at edge N presents bit k after edges N+k*DIV .. N+(k+1)*DIV-1.
  int          divs [2] = '{1, 3};
  logic        m_active [2] = '{1'b0, 1'b0};
  logic        m_pend_full [2] = '{1'b0, 1'b0};
  logic        m_out [2] = '{1'b0, 1'b0};
  logic [15:0] m_cur [2] = '{16'h0, 16'h0};
  logic [15:0] m_pend [2] = '{16'h0, 16'h0};
  int          m_pos [2] = '{0, 0};
  int          m_sent [2] = '{0, 0};

  function automatic logic nth_bit(input logic [15:0] w, input int k);
`ifdef SER_MSB_FIRST_EN
    return w[15-k];
`else
    return w[k];
`endif
  endfunction

  task automatic model_step(input int i);
    logic xfer;
    logic taken;
    if (rst) begin
      m_active[i] = 1'b0; m_pend_full[i] = 1'b0; m_out[i] = 1'b0;
      m_pos[i] = 0; m_sent[i] = 0;
      return;
    end
    xfer  = vld[i] && !m_pend_full[i];
    taken = 1'b0;
    if (m_active[i]) begin
      m_pos[i]++;
      if (m_pos[i] == W * divs[i]) begin
        m_sent[i] = (m_sent[i] + 1) % 256;
        if (m_pend_full[i]) begin
          m_cur[i] = m_pend[i]; m_pend_full[i] = 1'b0; m_pos[i] = 0;
        end else if (xfer) begin
          m_cur[i] = dat[i]; m_pos[i] = 0; taken = 1'b1;
        end else begin
          m_active[i] = 1'b0;
        end
      end
    end else if (xfer) begin
      m_active[i] = 1'b1; m_cur[i] = dat[i]; m_pos[i] = 0; taken = 1'b1;
    end
    if (xfer && !taken) begin
      m_pend[i] = dat[i]; m_pend_full[i] = 1'b1;
    end
    if (m_active[i]) m_out[i] = nth_bit(m_cur[i], m_pos[i] / divs[i]);
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk("in_ready", i, 64'(rdy[i]), 64'(!m_pend_full[i]));
        chk("busy", i, 64'(bsy[i]), 64'(m_active[i] || m_pend_full[i]));
        chk("ser_valid", i, 64'(sv[i]), 64'(m_active[i] && (m_pos[i] % divs[i] == 0)));
        chk("ser_out", i, 64'(so[i]), 64'(m_out[i]));
        chk("words_sent", i, 64'(ws[i]), 64'(m_sent[i]));
      end
    end
  end

  logic [63:0] co;
  logic [63:0] cv;

  task automatic cap(input int i, input int n);
    co = '0; cv = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      co[k] = so[i];
      cv[k] = sv[i];
    end
  endtask

  task automatic send(input int i, input logic [15:0] d);
    int n = 0;
    vld[i] = 1'b1;
    dat[i] = d;
    while (!rdy[i] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", i, 64'(rdy[i]), 64'd1);
    @(negedge clk);
    vld[i] = 1'b0;
    dat[i] = 16'($urandom);
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (bsy[i] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", i, 64'(bsy[i]), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic rand_stream(input int i, input int nwords);
    for (int n = 0; n < nwords; n++) begin
      repeat ($urandom_range(0, 3) == 0 ? $urandom_range(0, 60) : 0) @(negedge clk);
      send(i, 16'($urandom));
    end
  endtask

  initial begin
    vld[0] = 1'b0; vld[1] = 1'b0;
    dat[0] = 16'h0; dat[1] = 16'h0;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", i, 64'(rdy[i]), 64'd1);
      chk("rst_busy", i, 64'(bsy[i]), 64'd0);
      chk("rst_ser_valid", i, 64'(sv[i]), 64'd0);
      chk("rst_ser_out", i, 64'(so[i]), 64'd0);
      chk("rst_words_sent", i, 64'(ws[i]), 64'd0);
    end

    // Single word at DIV=1
    fork
      send(0, 16'b0101_0110_1101_0010);
      cap(0, 17);
    join
`ifdef SER_MSB_FIRST_EN
    chk("single_bits", 0, 64'(co[15:0]), 64'h4B6A);
`else
    chk("single_bits", 0, 64'(co[15:0]), 64'h56D2);
    chk("single_bits_4_8", 0, 64'(co[8:4]), 64'(5'b01101));
`endif
    chk("single_valid", 0, 64'(cv[15:0]), 64'hFFFF);
    chk("single_end_valid", 0, 64'(sv[0]), 64'd0);
    chk("single_end_busy", 0, 64'(bsy[0]), 64'd0);
    chk("single_end_count", 0, 64'(ws[0]), 64'd1);

    // Back-to-back through the holding register
    do_reset();
    fork
      begin
        send(0, 16'hFFFF);
        send(0, 16'h0000);
        chk("b2b_held_rdy", 0, 64'(rdy[0]), 64'd0);
      end
      cap(0, 33);
    join
    chk("b2b_bits", 0, 64'(co[31:0]), 64'h0000_FFFF);
    chk("b2b_valid", 0, 64'(cv[31:0]), 64'hFFFF_FFFF);
    chk("b2b_end_valid", 0, 64'(sv[0]), 64'd0);
    chk("b2b_count", 0, 64'(ws[0]), 64'd2);

    // DIV=3 bit periods
    fork
      send(1, 16'h0001);
      cap(1, 48);
    join
`ifdef SER_MSB_FIRST_EN
    chk("div3_bits", 1, co[47:0], 64'hE000_0000_0000);
`else
    chk("div3_bits", 1, co[47:0], 64'h7);
`endif
    chk("div3_valid", 1, cv[47:0], 64'h2492_4924_9249);
    wait_idle(1);
    chk("div3_count", 1, 64'(ws[1]), 64'd1);

    // Bit order
    fork
      send(0, 16'h8000);
      cap(0, 16);
    join
`ifdef SER_MSB_FIRST_EN
    chk("order_bits", 0, 64'(co[15:0]), 64'h0001);
`else
    chk("order_bits", 0, 64'(co[15:0]), 64'h8000);
`endif
    wait_idle(0);

    // Reset mid-word with a word held
    send(0, 16'hA5A5);
    send(0, 16'h1234);
    send(0, 16'h5678);
    repeat (4) @(negedge clk);
    chk("mid_pre_held", 0, 64'(rdy[0]), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_ser_out", 0, 64'(so[0]), 64'd0);
    chk("mid_ser_valid", 0, 64'(sv[0]), 64'd0);
    chk("mid_busy", 0, 64'(bsy[0]), 64'd0);
    chk("mid_words_sent", 0, 64'(ws[0]), 64'd0);
    chk("mid_in_ready", 0, 64'(rdy[0]), 64'd1);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", 0, 64'(rdy[0]), 64'd1);
    chk("post_rst_busy", 0, 64'(bsy[0]), 64'd0);

    // Randomized traffic on both instances
    fork
      rand_stream(0, 60);
      rand_stream(1, 30);
    join
    wait_idle(0);
    wait_idle(1);

    // Counter wrap after 256 words
    do_reset();
    for (int n = 0; n < 256; n++) send(0, 16'($urandom));
    wait_idle(0);
    chk("wrap_count", 0, 64'(ws[0]), 64'd0);
    send(0, 16'h00FF);
    wait_idle(0);
    chk("wrap_plus_one", 0, 64'(ws[0]), 64'd1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
